// File: rtl/Purple_Jade_pkg.sv
// Shared core types: word/tag widths, CDB broadcast format, and the
// reservation-station entry layout used by mult_rs.
package Purple_Jade_pkg;
  localparam int WORD_SIZE_P     = 32;
  localparam int ROB_ENTRY       = 16;
  localparam int NUM_PHYS_REG    = 64;
  localparam int TAG_W           = $clog2(NUM_PHYS_REG);
  localparam int ROB_W           = $clog2(ROB_ENTRY);
  localparam int RS_MULT_ENTRIES = 4;

  typedef struct packed {
    logic                   valid;
    logic [TAG_W-1:0]       dest;
    logic [3:0]             flags;
    logic [WORD_SIZE_P-1:0] result;
  } cdb_t;

  localparam int CDB_WIDTH = $bits(cdb_t);

  typedef struct packed {
    logic                   valid;
    logic                   rdy1;
    logic [TAG_W-1:0]       tag1;
    logic [WORD_SIZE_P-1:0] val1;
    logic                   rdy2;
    logic [TAG_W-1:0]       tag2;
    logic [WORD_SIZE_P-1:0] val2;
    logic [ROB_W-1:0]       rob_dest;
    logic [TAG_W-1:0]       reg_dest;
  } rs_entry_t;
endpackage

// File: rtl/mult_rs_if.sv
// Dispatch / CDB / issue bundle between the scheduler, mult_rs and fu_mult.
interface mult_rs_if import Purple_Jade_pkg::*; #(parameter int NUM_CDB = 2) ();
  logic                   disp_v_i;
  logic                   disp_src1_rdy_i;
  logic [TAG_W-1:0]       disp_src1_tag_i;
  logic [WORD_SIZE_P-1:0] disp_src1_val_i;
  logic                   disp_src2_rdy_i;
  logic [TAG_W-1:0]       disp_src2_tag_i;
  logic [WORD_SIZE_P-1:0] disp_src2_val_i;
  logic [ROB_W-1:0]       disp_rob_dest_i;
  logic [TAG_W-1:0]       disp_reg_dest_i;
  cdb_t [NUM_CDB-1:0]     cdb_i;
  logic                   mispredict_i;
  logic                   full_o;
  logic                   exe_v_o;
  logic [WORD_SIZE_P-1:0] operand1_o;
  logic [WORD_SIZE_P-1:0] operand2_o;
  logic [ROB_W-1:0]       rob_dest_o;
  logic [TAG_W-1:0]       reg_dest_o;

  modport slave (
    input  disp_v_i, disp_src1_rdy_i, disp_src1_tag_i, disp_src1_val_i,
           disp_src2_rdy_i, disp_src2_tag_i, disp_src2_val_i,
           disp_rob_dest_i, disp_reg_dest_i, cdb_i, mispredict_i,
    output full_o, exe_v_o, operand1_o, operand2_o, rob_dest_o, reg_dest_o
  );
  modport master (
    output disp_v_i, disp_src1_rdy_i, disp_src1_tag_i, disp_src1_val_i,
           disp_src2_rdy_i, disp_src2_tag_i, disp_src2_val_i,
           disp_rob_dest_i, disp_reg_dest_i, cdb_i, mispredict_i,
    input  full_o, exe_v_o, operand1_o, operand2_o, rob_dest_o, reg_dest_o
  );
endinterface

// File: rtl/rs_wakeup.sv
// Matches one operand (rdy, tag, val) against every CDB port and returns the
// operand's next ready/value; the lowest-numbered matching port wins.
module rs_wakeup import Purple_Jade_pkg::*; #(parameter int NUM_CDB = 2) (
  input  logic                   rdy,
  input  logic [TAG_W-1:0]       tag,
  input  logic [WORD_SIZE_P-1:0] val,
  input  cdb_t [NUM_CDB-1:0]     cdb,
  output logic                   rdy_nxt,
  output logic [WORD_SIZE_P-1:0] val_nxt
);
  logic unused_flags;

  always_comb begin
    rdy_nxt = rdy;
    val_nxt = val;
    // Walk high to low so the lowest matching port is written last.
    if (!rdy)
      for (int k = NUM_CDB-1; k >= 0; k--)
        if (cdb[k].valid && cdb[k].dest == tag) begin
          rdy_nxt = 1'b1;
          val_nxt = cdb[k].result;
        end
  end

  always_comb begin
    unused_flags = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) unused_flags = unused_flags ^ (^cdb[k].flags);
  end
endmodule

// File: rtl/mult_rs.sv
// Multiply reservation station: compacting queue (entry 0 oldest), CDB wakeup,
// oldest-ready single issue to fu_mult, wholesale flush on mispredict.
module mult_rs import Purple_Jade_pkg::*; #(
  parameter int RS_ENTRIES    = RS_MULT_ENTRIES,
  parameter int NUM_CDB       = 2,
  parameter bit CHK_DISP_FULL = 1'b1
) (
  input logic       clk_i,
  input logic       reset_i,
  mult_rs_if.slave  rs
);
  localparam int IDX_W = $clog2(RS_ENTRIES);

  rs_entry_t ent  [RS_ENTRIES];
  rs_entry_t woke [RS_ENTRIES];
  rs_entry_t nxt  [RS_ENTRIES];
  rs_entry_t disp;

  logic [RS_ENTRIES-1:0]                  vld_vec, w_rdy1, w_rdy2;
  logic [RS_ENTRIES-1:0][WORD_SIZE_P-1:0] w_val1, w_val2;
  logic                                   d_rdy1, d_rdy2;
  logic [WORD_SIZE_P-1:0]                 d_val1, d_val2;
  logic                                   found, disp_ok, placed;
  logic [IDX_W-1:0]                       sel;

  for (genvar i = 0; i < RS_ENTRIES; i++) begin : g_ent
    assign vld_vec[i] = ent[i].valid;
    rs_wakeup #(.NUM_CDB(NUM_CDB)) u_w1 (
      .rdy(ent[i].rdy1), .tag(ent[i].tag1), .val(ent[i].val1), .cdb(rs.cdb_i),
      .rdy_nxt(w_rdy1[i]), .val_nxt(w_val1[i]));
    rs_wakeup #(.NUM_CDB(NUM_CDB)) u_w2 (
      .rdy(ent[i].rdy2), .tag(ent[i].tag2), .val(ent[i].val2), .cdb(rs.cdb_i),
      .rdy_nxt(w_rdy2[i]), .val_nxt(w_val2[i]));
  end

  // Dispatch bypass: a tag broadcast in the dispatch cycle is captured ready.
  rs_wakeup #(.NUM_CDB(NUM_CDB)) u_b1 (
    .rdy(rs.disp_src1_rdy_i), .tag(rs.disp_src1_tag_i), .val(rs.disp_src1_val_i),
    .cdb(rs.cdb_i), .rdy_nxt(d_rdy1), .val_nxt(d_val1));
  rs_wakeup #(.NUM_CDB(NUM_CDB)) u_b2 (
    .rdy(rs.disp_src2_rdy_i), .tag(rs.disp_src2_tag_i), .val(rs.disp_src2_val_i),
    .cdb(rs.cdb_i), .rdy_nxt(d_rdy2), .val_nxt(d_val2));

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = RS_ENTRIES-1; i >= 0; i--)
      if (ent[i].valid && ent[i].rdy1 && ent[i].rdy2) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
  end

  assign rs.full_o     = &vld_vec;
  assign rs.exe_v_o    = found & ~rs.mispredict_i;
  assign rs.operand1_o = found ? ent[sel].val1     : '0;
  assign rs.operand2_o = found ? ent[sel].val2     : '0;
  assign rs.rob_dest_o = found ? ent[sel].rob_dest : '0;
  assign rs.reg_dest_o = found ? ent[sel].reg_dest : '0;

  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      woke[i]      = ent[i];
      woke[i].rdy1 = w_rdy1[i];
      woke[i].val1 = w_val1[i];
      woke[i].rdy2 = w_rdy2[i];
      woke[i].val2 = w_val2[i];
    end
  end

  always_comb begin
    disp          = '0;
    disp.valid    = 1'b1;
    disp.rdy1     = d_rdy1;
    disp.tag1     = rs.disp_src1_tag_i;
    disp.val1     = d_val1;
    disp.rdy2     = d_rdy2;
    disp.tag2     = rs.disp_src2_tag_i;
    disp.val2     = d_val2;
    disp.rob_dest = rs.disp_rob_dest_i;
    disp.reg_dest = rs.disp_reg_dest_i;
  end

  // Woken entries shift down past the issued slot, then dispatch fills the
  // first hole; full_o is the pre-issue view, so full+issue still rejects.
  always_comb begin
    disp_ok = rs.disp_v_i & ~rs.full_o & ~rs.mispredict_i;
    placed  = 1'b0;
    for (int i = 0; i < RS_ENTRIES-1; i++)
      nxt[i] = (found && IDX_W'(i) >= sel) ? woke[i+1] : woke[i];
    nxt[RS_ENTRIES-1] = found ? '0 : woke[RS_ENTRIES-1];
    for (int i = 0; i < RS_ENTRIES; i++)
      if (disp_ok && !placed && !nxt[i].valid) begin
        nxt[i] = disp;
        placed = 1'b1;
      end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < RS_ENTRIES; i++)
      if (reset_i || rs.mispredict_i) ent[i] <= '0;
      else                            ent[i] <= nxt[i];
  end

  assert property (@(posedge clk_i) disable iff (reset_i || !CHK_DISP_FULL)
    !(rs.disp_v_i && rs.full_o));
endmodule

// File: tb/tb_mult_rs.sv
// Directed scenarios plus a random-traffic queue model for mult_rs.
module tb_mult_rs;
  import Purple_Jade_pkg::*;

  logic clk, rst;
  int   n_chk = 0, n_pass = 0;
  logic [74:0] iss, e;

  mult_rs_if #(.NUM_CDB(2)) bus ();
  mult_rs #(.RS_ENTRIES(4), .NUM_CDB(2), .CHK_DISP_FULL(1'b0)) dut (
    .clk_i(clk), .reset_i(rst), .rs(bus));

  assign iss = {bus.exe_v_o, bus.operand1_o, bus.operand2_o, bus.rob_dest_o, bus.reg_dest_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    bus.disp_v_i = 0; bus.disp_src1_rdy_i = 0; bus.disp_src1_tag_i = '0; bus.disp_src1_val_i = '0;
    bus.disp_src2_rdy_i = 0; bus.disp_src2_tag_i = '0; bus.disp_src2_val_i = '0;
    bus.disp_rob_dest_i = '0; bus.disp_reg_dest_i = '0; bus.cdb_i = '0; bus.mispredict_i = 0;
  endtask

  task automatic disp(input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [5:0] t2, input logic [31:0] v2,
                      input logic [3:0] rob, input logic [5:0] rg);
    bus.disp_v_i = 1; bus.disp_src1_rdy_i = r1; bus.disp_src1_tag_i = t1; bus.disp_src1_val_i = v1;
    bus.disp_src2_rdy_i = r2; bus.disp_src2_tag_i = t2; bus.disp_src2_val_i = v2;
    bus.disp_rob_dest_i = rob; bus.disp_reg_dest_i = rg;
  endtask

  task automatic cdb(input int k, input logic [5:0] dest, input logic [31:0] res);
    bus.cdb_i[k].valid = 1; bus.cdb_i[k].dest = dest; bus.cdb_i[k].result = res; bus.cdb_i[k].flags = 4'hF;
  endtask

  task automatic test_reset();
    rst = 1; idle(); disp(1, 0, 32'd1, 1, 0, 32'd1, 4'd1, 6'd1);
    repeat (3) tick();
    #1;
    n_chk++; if (bus.full_o !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus.full_o); else n_pass++;
    n_chk++; if (iss !== 75'd0) $display("FAIL reset_outputs got=%h exp=0", iss); else n_pass++;
    rst = 0; idle();
    tick();
  endtask

  task automatic test_basic();
    idle(); disp(1, 0, 32'd3, 1, 0, 32'd5, 4'd1, 6'd10); #1;
    n_chk++; if (bus.exe_v_o !== 1'b0) $display("FAIL basic_empty got=%b exp=0", bus.exe_v_o); else n_pass++;
    tick(); idle(); #1;
    e = {1'b1, 32'd3, 32'd5, 4'd1, 6'd10};
    n_chk++; if (iss !== e) $display("FAIL basic_issue got=%h exp=%h", iss, e); else n_pass++;
    n_chk++; if (bus.operand1_o * bus.operand2_o !== 32'd15)
      $display("FAIL basic_product got=%0d exp=15", bus.operand1_o * bus.operand2_o); else n_pass++;
    tick(); #1;
    n_chk++; if (bus.exe_v_o !== 1'b0) $display("FAIL basic_once got=%b exp=0", bus.exe_v_o); else n_pass++;
  endtask

  task automatic test_order();
    idle(); disp(0, 6'd7, 32'd0, 1, 0, 32'd4, 4'd2, 6'd11); tick();
    idle(); disp(1, 0, 32'd6, 1, 0, 32'd7, 4'd3, 6'd12); #1;
    n_chk++; if (bus.exe_v_o !== 1'b0) $display("FAIL order_a_wait got=%b exp=0", bus.exe_v_o); else n_pass++;
    tick(); idle(); #1;
    e = {1'b1, 32'd6, 32'd7, 4'd3, 6'd12};
    n_chk++; if (iss !== e) $display("FAIL order_b_first got=%h exp=%h", iss, e); else n_pass++;
    tick(); cdb(0, 6'd7, 32'd9); #1;
    n_chk++; if (bus.exe_v_o !== 1'b0) $display("FAIL order_no_same_cycle got=%b exp=0", bus.exe_v_o); else n_pass++;
    tick(); idle(); #1;
    e = {1'b1, 32'd9, 32'd4, 4'd2, 6'd11};
    n_chk++; if (iss !== e) $display("FAIL order_a_woken got=%h exp=%h", iss, e); else n_pass++;
    tick(); #1;
    n_chk++; if (bus.exe_v_o !== 1'b0) $display("FAIL order_drained got=%b exp=0", bus.exe_v_o); else n_pass++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      idle(); disp(0, 6'(20 + i), 32'd0, 1, 0, 32'(100 + i), 4'(4 + i), 6'(i)); tick();
    end
    idle(); disp(1, 0, 32'd1, 1, 0, 32'd1, 4'd15, 6'd15);
    repeat (2) begin
      #1;
      n_chk++; if (bus.full_o !== 1'b1) $display("FAIL full_set got=%b exp=1", bus.full_o); else n_pass++;
      n_chk++; if (bus.exe_v_o !== 1'b0) $display("FAIL full_ignored got=%b exp=0", bus.exe_v_o); else n_pass++;
      tick();
    end
    cdb(0, 6'd22, 32'h55); tick(); bus.cdb_i = '0; #1;
    e = {1'b1, 32'h55, 32'd102, 4'd6, 6'd2};
    n_chk++; if (iss !== e) $display("FAIL full_wake_entry2 got=%h exp=%h", iss, e); else n_pass++;
    n_chk++; if (bus.full_o !== 1'b1) $display("FAIL full_during_issue got=%b exp=1", bus.full_o); else n_pass++;
    tick(); idle(); #1;
    n_chk++; if (bus.full_o !== 1'b0) $display("FAIL full_clear got=%b exp=0", bus.full_o); else n_pass++;
    n_chk++; if (bus.exe_v_o !== 1'b0) $display("FAIL full_rejected got=%b exp=0", bus.exe_v_o); else n_pass++;
    cdb(0, 6'd23, 32'h77); cdb(1, 6'd20, 32'h66); tick(); idle(); #1;
    e = {1'b1, 32'h66, 32'd100, 4'd4, 6'd0};
    n_chk++; if (iss !== e) $display("FAIL full_order0 got=%h exp=%h", iss, e); else n_pass++;
    tick(); #1;
    e = {1'b1, 32'h77, 32'd103, 4'd7, 6'd3};
    n_chk++; if (iss !== e) $display("FAIL full_order1 got=%h exp=%h", iss, e); else n_pass++;
    tick(); cdb(0, 6'd21, 32'h88); tick(); idle(); #1;
    e = {1'b1, 32'h88, 32'd101, 4'd5, 6'd1};
    n_chk++; if (iss !== e) $display("FAIL full_order2 got=%h exp=%h", iss, e); else n_pass++;
    tick();
  endtask

  task automatic test_bypass();
    idle(); disp(0, 6'd12, 32'd0, 1, 0, 32'd2, 4'd8, 6'd3);
    cdb(1, 6'd12, 32'hABCD); cdb(0, 6'd13, 32'h1234); tick(); idle(); #1;
    e = {1'b1, 32'hABCD, 32'd2, 4'd8, 6'd3};
    n_chk++; if (iss !== e) $display("FAIL bypass_port1 got=%h exp=%h", iss, e); else n_pass++;
    tick();
    disp(0, 6'd14, 32'd0, 0, 6'd14, 32'd0, 4'd9, 6'd4);
    cdb(0, 6'd14, 32'h1111); cdb(1, 6'd14, 32'h2222); tick(); idle(); #1;
    e = {1'b1, 32'h1111, 32'h1111, 4'd9, 6'd4};
    n_chk++; if (iss !== e) $display("FAIL bypass_low_port got=%h exp=%h", iss, e); else n_pass++;
    tick(); #1;
    n_chk++; if (bus.exe_v_o !== 1'b0) $display("FAIL bypass_drained got=%b exp=0", bus.exe_v_o); else n_pass++;
  endtask

  task automatic test_flush();
    idle(); disp(0, 6'd30, 32'd0, 1, 0, 32'd1, 4'd10, 6'd5); tick();
    idle(); disp(0, 6'd31, 32'd0, 1, 0, 32'd2, 4'd11, 6'd6); tick();
    idle(); cdb(0, 6'd30, 32'hA); cdb(1, 6'd31, 32'hB); tick(); idle(); #1;
    e = {1'b1, 32'hA, 32'd1, 4'd10, 6'd5};
    n_chk++; if (iss !== e) $display("FAIL flush_pre got=%h exp=%h", iss, e); else n_pass++;
    bus.mispredict_i = 1; disp(1, 0, 32'd7, 1, 0, 32'd8, 4'd12, 6'd7); #1;
    n_chk++; if (bus.exe_v_o !== 1'b0) $display("FAIL flush_kill got=%b exp=0", bus.exe_v_o); else n_pass++;
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if ({bus.exe_v_o, bus.full_o} !== 2'b00)
        $display("FAIL flush_empty got=%b exp=00", {bus.exe_v_o, bus.full_o}); else n_pass++;
      tick();
    end
  endtask

  function automatic rs_entry_t wake_ent(input rs_entry_t x, input cdb_t [1:0] c);
    logic h1, h2;
    h1 = x.rdy1; h2 = x.rdy2;
    for (int k = 0; k < 2; k++) begin
      if (!h1 && c[k].valid && c[k].dest == x.tag1) begin x.rdy1 = 1; x.val1 = c[k].result; h1 = 1; end
      if (!h2 && c[k].valid && c[k].dest == x.tag2) begin x.rdy2 = 1; x.val2 = c[k].result; h2 = 1; end
    end
    return x;
  endfunction

  task automatic test_random();
    rs_entry_t q[$];
    rs_entry_t d;
    logic [3:0] rob_ctr = 0;
    logic found, xfull, mp;
    int idx;
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        disp(1'($urandom_range(0, 2) != 0), 6'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 2) != 0), 6'($urandom_range(0, 7)), $urandom,
             rob_ctr, 6'($urandom_range(0, 63)));
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 2) == 0) cdb(k, 6'($urandom_range(0, 7)), $urandom);
      mp = ($urandom_range(0, 63) == 0);
      bus.mispredict_i = mp;
      #1;
      found = 0; idx = 0;
      for (int i = 0; i < q.size(); i++)
        if (!found && q[i].rdy1 && q[i].rdy2) begin found = 1; idx = i; end
      xfull = (q.size() == 4);
      n_chk++; if ({bus.full_o, bus.exe_v_o} !== {xfull, found && !mp})
        $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c, {bus.full_o, bus.exe_v_o}, {xfull, found && !mp});
      else n_pass++;
      if (found && !mp) begin
        e = {1'b1, q[idx].val1, q[idx].val2, q[idx].rob_dest, q[idx].reg_dest};
        n_chk++; if (iss !== e) $display("FAIL rand_issue cyc=%0d got=%h exp=%h", c, iss, e); else n_pass++;
      end
      if (mp) q.delete();
      else begin
        if (found) q.delete(idx);
        foreach (q[i]) q[i] = wake_ent(q[i], bus.cdb_i);
        if (bus.disp_v_i && !xfull) begin
          d = '0; d.valid = 1;
          d.rdy1 = bus.disp_src1_rdy_i; d.tag1 = bus.disp_src1_tag_i; d.val1 = bus.disp_src1_val_i;
          d.rdy2 = bus.disp_src2_rdy_i; d.tag2 = bus.disp_src2_tag_i; d.val2 = bus.disp_src2_val_i;
          d.rob_dest = bus.disp_rob_dest_i; d.reg_dest = bus.disp_reg_dest_i;
          q.push_back(wake_ent(d, bus.cdb_i));
          rob_ctr++;
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1; idle();
    test_reset();
    test_basic();
    test_order();
    test_full();
    test_bypass();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
